// File: rtl/ps2_key_tracker_if.sv
// Key-event bus between the PS/2 tracker (master) and the decode/display stage (slave).
interface ps2_key_tracker_if;
  logic       evt_rd;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (
    input  evt_rd,
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_brk
  );

  modport slave (
    output evt_rd,
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_brk
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 receiver, E0/F0 prefix resolver, typematic filter and first-word-fall-through event FIFO.
// Optional inactivity watchdog on partial frames: define PS2_TIMEOUT_EN.
module ps2_key_tracker #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_key_tracker_if.master    evt,
  output logic                 key_held,
  output logic [7:0]           held_code,
  output logic                 held_ext,
  output logic [CNT_W-1:0]     press_count,
  output logic                 fifo_overflow,
  output logic                 frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } pfx_state_t;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("ps2_key_tracker: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic logic is_silent(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  logic [1:0]  ps2_clk_sync_r;
  logic [1:0]  ps2_data_sync_r;
  logic        ps2_clk_prev_r;
  logic        fall_s;
  logic [10:0] shift_r;
  logic [3:0]  bit_cnt_r;
  logic [10:0] frame_s;
  logic        frame_ok_s;
  logic        byte_vld_r;
  logic [7:0]  byte_r;
  logic        frame_bad_r;
  logic        frame_err_r;
  logic        timeout_s;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync_r  <= 2'b00;
      ps2_data_sync_r <= 2'b00;
      ps2_clk_prev_r  <= 1'b0;
    end else begin
      ps2_clk_sync_r  <= {ps2_clk_sync_r[0], ps2_clk};
      ps2_data_sync_r <= {ps2_data_sync_r[0], ps2_data};
      ps2_clk_prev_r  <= ps2_clk_sync_r[1];
    end
  end

  assign fall_s     = ps2_clk_prev_r & ~ps2_clk_sync_r[1];
  assign frame_s    = {ps2_data_sync_r[1], shift_r[10:1]};
  assign frame_ok_s = (frame_s[0] == 1'b0) && frame_s[10] && odd_parity_ok(frame_s[8:1], frame_s[9]);

`ifdef PS2_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_r;

  // Inactivity counter; only runs while a frame is partially received.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (fall_s || (bit_cnt_r == 4'd0)) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    end
  end

  assign timeout_s = (bit_cnt_r != 4'd0) && !fall_s && (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_r     <= 11'd0;
      bit_cnt_r   <= 4'd0;
      byte_vld_r  <= 1'b0;
      byte_r      <= 8'd0;
      frame_bad_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      byte_vld_r  <= 1'b0;
      frame_bad_r <= 1'b0;
      frame_err_r <= timeout_s;
      if (timeout_s) begin
        shift_r   <= 11'd0;
        bit_cnt_r <= 4'd0;
      end else if (fall_s) begin
        shift_r <= frame_s;
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r   <= 4'd0;
          byte_r      <= frame_s[8:1];
          byte_vld_r  <= frame_ok_s;
          frame_bad_r <= !frame_ok_s;
          frame_err_r <= !frame_ok_s;
        end else begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
      end
    end
  end

  assign frame_err = frame_err_r;

  pfx_state_t state_r, state_nx_s;
  logic       emit_s, emit_ext_s, emit_brk_s;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // A rejected frame abandons any pending prefix.
  always_comb begin
    state_nx_s = state_r;
    if (frame_bad_r) begin
      state_nx_s = ST_IDLE;
    end else if (byte_vld_r) begin
      case (state_r)
        ST_IDLE: begin
          if (byte_r == 8'hE0) begin
            state_nx_s = ST_E0;
          end else if (byte_r == 8'hF0) begin
            state_nx_s = ST_F0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_E0: begin
          if (byte_r == 8'hF0) begin
            state_nx_s = ST_E0F0;
          end else if (byte_r == 8'hE0) begin
            state_nx_s = ST_E0;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_F0:   state_nx_s = ST_IDLE;
        ST_E0F0: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  always_comb begin
    emit_s     = 1'b0;
    emit_ext_s = 1'b0;
    emit_brk_s = 1'b0;
    if (byte_vld_r) begin
      case (state_r)
        ST_IDLE: emit_s = (byte_r != 8'hE0) && (byte_r != 8'hF0) && !is_silent(byte_r);
        ST_E0: begin
          emit_s     = (byte_r != 8'hE0) && (byte_r != 8'hF0);
          emit_ext_s = 1'b1;
        end
        ST_F0: begin
          emit_s     = 1'b1;
          emit_brk_s = 1'b1;
        end
        ST_E0F0: begin
          emit_s     = 1'b1;
          emit_ext_s = 1'b1;
          emit_brk_s = 1'b1;
        end
        default: begin
          emit_s     = 1'b0;
          emit_ext_s = 1'b0;
          emit_brk_s = 1'b0;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  logic       match_s;
  logic       push_r;
  logic [9:0] push_evt_r;

  assign match_s = key_held && (held_code == byte_r) && (held_ext == emit_ext_s);

  // Typematic filter: repeats of the held make vanish; breaks are always queued.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      push_r      <= 1'b0;
      push_evt_r  <= 10'd0;
      key_held    <= 1'b0;
      held_code   <= 8'd0;
      held_ext    <= 1'b0;
      press_count <= {CNT_W{1'b0}};
    end else begin
      push_r <= 1'b0;
      if (emit_s) begin
        push_evt_r <= {emit_ext_s, emit_brk_s, byte_r};
        if (emit_brk_s) begin
          push_r <= 1'b1;
          if (match_s) begin
            key_held <= 1'b0;
          end
        end else if (!match_s) begin
          push_r      <= 1'b1;
          press_count <= press_count + {{(CNT_W-1){1'b0}}, 1'b1};
          key_held    <= 1'b1;
          held_code   <= byte_r;
          held_ext    <= emit_ext_s;
        end
      end
    end
  end

  logic [9:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic        empty_s, full_s, pop_s, push_ok_s;
  logic [9:0]  head_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s     = evt.evt_rd && !empty_s;
  assign push_ok_s = push_r && (!full_s || pop_s);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
      wr_ptr_r      <= {(AW+1){1'b0}};
      rd_ptr_r      <= {(AW+1){1'b0}};
      fifo_overflow <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_evt_r;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (push_r && full_s && !pop_s) begin
        fifo_overflow <= 1'b1;
      end
    end
  end

  assign head_s        = mem_r[rd_ptr_r[AW-1:0]];
  assign evt.evt_valid = !empty_s;
  assign evt.evt_code  = head_s[7:0];
  assign evt.evt_brk   = head_s[8];
  assign evt.evt_ext   = head_s[9];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Table-driven bench for ps2_key_tracker with an expected-event scoreboard queue.
`timescale 1ns/1ps
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_held, held_ext, fifo_overflow, frame_err;
  logic [7:0] held_code;
  logic [7:0] press_count;

  ps2_key_tracker_if evt_bus ();

  ps2_key_tracker #(.FIFO_DEPTH(8), .CNT_W(8), .TIMEOUT_CYC(100)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .evt          (evt_bus),
    .key_held     (key_held),
    .held_code    (held_code),
    .held_ext     (held_ext),
    .press_count  (press_count),
    .fifo_overflow(fifo_overflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  typedef struct {
    logic [7:0] data;
    bit         bad;
    bit         emit;
    bit         ext;
    bit         brk;
    int         press;
    bit         held;
  } vec_t;

  evt_t exp_q[$];
  vec_t tbl[23];
  int   n_checks = 0;
  int   n_errs = 0;
  int   err_cycles = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cycles <= err_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = ~(^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (5) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (5) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits(make_frame(b, bad), 11);
    repeat (10) @(posedge clk);
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Pops every event the DUT offers and matches it against the scoreboard.
  task automatic drain();
    evt_t e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (evt_bus.evt_valid !== 1'b1) break;
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {22'd0, evt_bus.evt_ext, evt_bus.evt_brk, evt_bus.evt_code}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("evt", {22'd0, evt_bus.evt_ext, evt_bus.evt_brk, evt_bus.evt_code}, {22'd0, e});
      end
      evt_bus.evt_rd = 1'b1;
      @(negedge clk);
      evt_bus.evt_rd = 1'b0;
    end
    check("missing_evts", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    evt_bus.evt_rd = 1'b0;

    //            data   bad   emit  ext   brk   press held
    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[1]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[3]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[4]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[6]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b1};
    tbl[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1};
    tbl[9]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0};
    tbl[10] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[11] = '{8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1};
    tbl[12] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1};
    tbl[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1};
    tbl[14] = '{8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0};
    tbl[15] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1};
    tbl[16] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1};
    tbl[17] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b1};
    tbl[18] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1};
    tbl[19] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b1};
    tbl[20] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1};
    tbl[21] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b1};
    tbl[22] = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_evt_valid", evt_bus.evt_valid, 1'b0);
    check("rst_press", press_count, 8'd0);
    check("rst_key_held", key_held, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_held_code", held_code, 8'd0);
    check("rst_overflow", fifo_overflow, 1'b0);
    check("rst_evt_code", evt_bus.evt_code, 8'd0);

    for (int i = 0; i < 23; i++) begin
      e0 = err_cycles;
      if (tbl[i].emit) expect_evt(tbl[i].ext, tbl[i].brk, tbl[i].data);
      send_byte(tbl[i].data, tbl[i].bad);
      check($sformatf("frame_err_%0d", i), err_cycles - e0, tbl[i].bad ? 1 : 0);
      drain();
      check($sformatf("press_%0d", i), press_count, tbl[i].press);
      check($sformatf("held_%0d", i), key_held, tbl[i].held);
    end
    check("held_code_end", held_code, 8'h1D);

    // Overflow: nine makes into an eight-deep FIFO with no reads.
    do_reset();
    @(negedge clk);
    evt_bus.evt_rd = 1'b1;
    @(negedge clk);
    evt_bus.evt_rd = 1'b0;
    check("empty_pop_ignored", evt_bus.evt_valid, 1'b0);
    begin
      logic [7:0] codes [9];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
      for (int i = 0; i < 9; i++) begin
        if (i < 8) expect_evt(1'b0, 1'b0, codes[i]);
        send_byte(codes[i], 1'b0);
        if (i == 7) check("ovf_before_full_push", fifo_overflow, 1'b0);
      end
    end
    check("ovf_set", fifo_overflow, 1'b1);
    check("ovf_press", press_count, 8'd9);
    drain();
    check("ovf_empty_after", evt_bus.evt_valid, 1'b0);
    check("ovf_sticky", fifo_overflow, 1'b1);

    // Reset in the middle of a frame discards the partial bits.
    do_reset();
    send_bits(make_frame(8'h1C, 1'b0), 5);
    do_reset();
    check("midframe_rst_ovf", fifo_overflow, 1'b0);
    e0 = err_cycles;
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C, 1'b0);
    drain();
    check("midframe_no_err", err_cycles - e0, 0);
    check("midframe_press", press_count, 8'd1);

    // Reset after an E0 prefix drops the pending extension.
    send_byte(8'hE0, 1'b0);
    do_reset();
    expect_evt(1'b0, 1'b0, 8'h75);
    send_byte(8'h75, 1'b0);
    drain();
    check("midpfx_held_ext", held_ext, 1'b0);

`ifdef PS2_TIMEOUT_EN
    do_reset();
    e0 = err_cycles;
    send_bits(make_frame(8'h1C, 1'b0), 5);
    repeat (150) @(negedge clk);
    check("timeout_err_pulse", err_cycles - e0, 1);
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C, 1'b0);
    drain();
    check("timeout_no_extra_err", err_cycles - e0, 1);
    check("timeout_press", press_count, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 keyboard front end that replaces the raw scan-code receiver in the keyboard/display path. Receives and validates PS/2 frames, then resolves E0/F0 prefix sequences into complete key events {ext, brk, code}. Filters typematic repeats and counts genuine key presses. Queues events in a depth-configurable FIFO for the decode/display stage.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2
CNT_W, 8, press counter width
TIMEOUT_CYC, 50000, clk cycles of ps2_clk inactivity that abort a partial frame (used only with the optional feature)

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
ps2_clk  in  1  raw keyboard clock, asynchronous
ps2_data  in  1  raw keyboard data, asynchronous
evt_rd  in  1  pop head event; honoured only when evt_valid=1
evt_valid  out  1  FIFO non-empty
evt_code  out  8  head event scan code
evt_ext  out  1  head event had an E0 prefix
evt_brk  out  1  head event is a release (F0 prefix)
key_held  out  1  a key is currently held
held_code  out  8  code of the held key
held_ext  out  1  ext flag of the held key
press_count  out  CNT_W  non-repeat make events, modulo 2^CNT_W
fifo_overflow  out  1  sticky flag: an event was dropped
frame_err  out  1  one-cycle pulse for a rejected frame

Behaviour:
- Reset: all outputs 0, FIFO empty, prefix FSM in IDLE, bit counter 0.
- Input capture: ps2_clk and ps2_data pass through 2-flop synchronisers. A falling edge is detected when the synchronised ps2_clk changes 1->0. On each falling edge, ps2_data is sampled into an 11-bit shift register, LSB first.
- Frame: start=0, 8 data bits, odd parity, stop=1. At the 11th bit the frame is checked. On any failure the byte is discarded, frame_err pulses for 1 cycle, and the FSM returns to IDLE.
- Prefix FSM states: IDLE, E0, F0, E0F0.
  - IDLE: E0->E0; F0->F0; 0xAA/FA/EE/FE/00/FF consumed silently; any other byte emits make{ext=0}.
  - E0: F0->E0F0; E0 stays in E0; other byte emits make{ext=1}, then IDLE.
  - F0: byte emits break{ext=0}, then IDLE.
  - E0F0: byte emits break{ext=1}, then IDLE.
- Latency: byte accepted in cycle N; event pushed in N+1; evt_valid and evt_* visible from N+2.
- Repeat filter: a make matching held_code/held_ext while key_held=1 is a typematic repeat. It is not queued and not counted.
  - Any other make is queued, press_count increments (wraps at 2^CNT_W), key_held=1, and held_code/held_ext are updated.
  - A break matching the held key clears key_held; held_code keeps its last value.
  - A break of any other key is queued, and held state is unchanged.
- FIFO: first-word fall-through.
  - evt_rd with evt_valid=0 is ignored.
  - Push when full with no pop in the same cycle: the event is dropped and fifo_overflow is set. fifo_overflow clears only on reset.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Simultaneous push and pop when empty: the push is stored, and the pop is ignored.
  - Pointers are log2(FIFO_DEPTH) bits wide plus a wrap bit.
- Reset asserted mid-frame or mid-prefix: everything clears immediately. The partial frame is lost.

Optional Feature:
PS2_TIMEOUT_EN
- Defined: a watchdog counts clk cycles since the last ps2_clk falling edge while the bit counter is non-zero. At TIMEOUT_CYC the bit counter and shift register clear, and frame_err pulses once. The prefix FSM is untouched.
- Undefined: no watchdog. A partial frame persists until further edges arrive.

Test Plan:
- Frame 0x1C (parity 0) -> after 2 cycles: evt_valid=1, evt_code=1C, evt_ext=0, evt_brk=0; press_count=1; key_held=1, held_code=1C.
- Bytes 1C,1C,1C,F0,1C -> exactly 2 events: make 1C, then break 1C (brk=1); press_count=1; key_held=0 at end.
- Bytes E0,75,E0,F0,75 -> events: {ext=1, brk=0, 75}, then {ext=1, brk=1, 75}; press_count=1.
- Frame 0x1C with parity bit 1 -> frame_err pulses 1 cycle, no event, press_count unchanged; next valid frame 0x32 is accepted.
- FIFO_DEPTH=8, makes 15,1D,24,2D,2C,35,3C,43,44 with no reads -> 8 events stored (15..43), fifo_overflow=1, press_count=9. Eight pops drain them in order; evt_valid=0 afterwards.
- PS2_TIMEOUT_EN, TIMEOUT_CYC=100: 5 bits, idle 150 cycles, then full frame 0x1C -> one frame_err pulse, then event 1C received correctly. Without the macro, the same stimulus produces frame_err or a wrong code.
